// File: rtl/alu_rs_scheduler_pkg.sv
// Shared widths, opcode constants, entry payload types and the operand wakeup helper
// for the ALU reservation station.
package alu_rs_scheduler_pkg;

  localparam int unsigned ROB_SIZE       = 16;
  localparam int unsigned ROB_SIZE_WIDTH = $clog2(ROB_SIZE);
  localparam int unsigned XLEN           = 32;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]           word_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
    word_t    val;
  } operand_t;

  typedef struct packed {
    rob_tag_t   rob_id;
    logic [2:0] op;
    logic [6:0] instr_type;
    logic       op_other;
    operand_t   src1;
    operand_t   src2;
  } rs_entry_t;

  // Capture a pending operand from a matching broadcast; ALU bus wins a tie.
  function automatic operand_t wake(operand_t o,
                                    logic alu_rdy, rob_tag_t alu_tag, word_t alu_res,
                                    logic lsb_rdy, rob_tag_t lsb_tag, word_t lsb_res);
    operand_t r;
    r = o;
    if (o.busy && alu_rdy && (o.tag == alu_tag)) begin
      r.busy = 1'b0;
      r.val  = alu_res;
    end else if (o.busy && lsb_rdy && (o.tag == lsb_tag)) begin
      r.busy = 1'b0;
      r.val  = lsb_res;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module rs_prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: dispatch into the lowest free slot, CDB wakeup with
// dispatch bypass, and one lowest-index ready issue per cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned RS_W    = $clog2(RS_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rob_clear,
  input  logic                      disp_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_rob_id,
  input  logic [2:0]                disp_op,
  input  logic [6:0]                disp_instr_type,
  input  logic                      disp_op_other,
  input  logic [31:0]               disp_v1,
  input  logic [31:0]               disp_v2,
  input  logic                      disp_q1_busy,
  input  logic                      disp_q2_busy,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_q1,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_q2,
  input  logic                      cdb_alu_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_rob_id,
  input  logic [31:0]               cdb_alu_result,
  input  logic                      cdb_lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_rob_id,
  input  logic [31:0]               cdb_lsb_result,
  output logic                      full,
  output logic                      issue_valid,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [2:0]                issue_op,
  output logic [6:0]                issue_instr_type,
  output logic                      issue_op_other,
  output logic [31:0]               issue_v1,
  output logic [31:0]               issue_v2
);

  rs_entry_t          entries [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  operand_t           wk1 [RS_SIZE];
  operand_t           wk2 [RS_SIZE];
  logic [RS_W-1:0]    free_idx;
  logic [RS_W-1:0]    sel_idx;
  logic               free_found;
  logic               sel_found;
  operand_t           disp_raw1;
  operand_t           disp_raw2;
  operand_t           disp_src1;
  operand_t           disp_src2;

  assign full     = &busy;
  assign free_vec = ~busy;

  // Per-entry, per-operand wakeup comparators and eligibility.
  for (genvar g = 0; g < int'(RS_SIZE); g++) begin : g_entry
    assign ready_vec[g] = busy[g] & ~entries[g].src1.busy & ~entries[g].src2.busy;
    assign wk1[g] = wake(entries[g].src1, cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
                         cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result);
    assign wk2[g] = wake(entries[g].src2, cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
                         cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result);
  end

  assign disp_raw1 = '{busy: disp_q1_busy, tag: disp_q1, val: disp_v1};
  assign disp_raw2 = '{busy: disp_q2_busy, tag: disp_q2, val: disp_v2};
  assign disp_src1 = wake(disp_raw1, cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
                          cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result);
  assign disp_src2 = wake(disp_raw2, cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
                          cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result);

  rs_prio_enc #(.N(RS_SIZE), .W(RS_W)) u_free_enc (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_W)) u_sel_enc (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Free search and select both use start-of-cycle busy, so an entry freed by
  // issue cannot be refilled until the next cycle.
  always_ff @(posedge clk) begin
    if (rst || rob_clear) begin
      busy             <= '0;
      issue_valid      <= 1'b0;
      issue_rob_id     <= '0;
      issue_op         <= '0;
      issue_instr_type <= '0;
      issue_op_other   <= 1'b0;
      issue_v1         <= '0;
      issue_v2         <= '0;
    end else if (rdy) begin
      issue_valid <= sel_found;
      if (sel_found) begin
        issue_rob_id     <= entries[sel_idx].rob_id;
        issue_op         <= entries[sel_idx].op;
        issue_instr_type <= entries[sel_idx].instr_type;
        issue_op_other   <= entries[sel_idx].op_other;
        issue_v1         <= entries[sel_idx].src1.val;
        issue_v2         <= entries[sel_idx].src2.val;
        busy[sel_idx]    <= 1'b0;
      end
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        entries[i].src1 <= wk1[i];
        entries[i].src2 <= wk2[i];
      end
      if (disp_valid && free_found) begin
        busy[free_idx]    <= 1'b1;
        entries[free_idx] <= '{rob_id:     disp_rob_id,
                               op:         disp_op,
                               instr_type: disp_instr_type,
                               op_other:   disp_op_other,
                               src1:       disp_src1,
                               src2:       disp_src2};
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench: a behavioural station model predicts the outputs after every
// edge; a monitor compares them against the DUT one step after the edge.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear, disp_valid;
  logic [3:0]  disp_rob_id, disp_q1, disp_q2;
  logic [2:0]  disp_op;
  logic [6:0]  disp_instr_type;
  logic        disp_op_other, disp_q1_busy, disp_q2_busy;
  logic [31:0] disp_v1, disp_v2;
  logic        cdb_alu_ready, cdb_lsb_ready;
  logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0] cdb_alu_result, cdb_lsb_result;
  logic        full, issue_valid, issue_op_other;
  logic [3:0]  issue_rob_id;
  logic [2:0]  issue_op;
  logic [6:0]  issue_instr_type;
  logic [31:0] issue_v1, issue_v2;

  alu_rs_scheduler #(.RS_SIZE(N)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .disp_valid(disp_valid), .disp_rob_id(disp_rob_id), .disp_op(disp_op),
    .disp_instr_type(disp_instr_type), .disp_op_other(disp_op_other),
    .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .cdb_alu_ready(cdb_alu_ready), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_result(cdb_alu_result),
    .cdb_lsb_ready(cdb_lsb_ready), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_result(cdb_lsb_result),
    .full(full), .issue_valid(issue_valid), .issue_rob_id(issue_rob_id), .issue_op(issue_op),
    .issue_instr_type(issue_instr_type), .issue_op_other(issue_op_other),
    .issue_v1(issue_v1), .issue_v2(issue_v2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy; logic [3:0] rob; logic [2:0] op; logic [6:0] it; bit oth;
    bit p1; logic [3:0] t1; logic [31:0] v1;
    bit p2; logic [3:0] t2; logic [31:0] v2;
  } m_ent_t;

  typedef struct {
    bit valid; bit full; logic [3:0] rob; logic [2:0] op; logic [6:0] it; bit oth;
    logic [31:0] v1; logic [31:0] v2;
  } exp_t;

  m_ent_t m [N];
  exp_t   mo;
  exp_t   q [$];
  bit     started = 0;
  int     total = 0;
  int     bad = 0;

  // Resolve a pending operand against the broadcasts currently on the buses.
  task automatic resolve(inout bit p, input logic [3:0] t, inout logic [31:0] v);
    if (p && cdb_alu_ready && t == cdb_alu_rob_id) begin p = 0; v = cdb_alu_result; end
    else if (p && cdb_lsb_ready && t == cdb_lsb_rob_id) begin p = 0; v = cdb_lsb_result; end
  endtask

  // Reference model: one update per clock edge from the station's rules.
  always @(posedge clk) begin : model
    int sel, fr, cnt;
    if (rst) started = 1;
    if (started) begin
      if (rst || rob_clear) begin
        for (int i = 0; i < N; i++) m[i].busy = 0;
        mo = '{default: 0};
      end else if (rdy) begin
        sel = -1; fr = -1;
        for (int i = 0; i < N; i++) begin
          if (sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) sel = i;
          if (fr < 0 && !m[i].busy) fr = i;
        end
        mo.valid = (sel >= 0);
        if (sel >= 0) begin
          mo.rob = m[sel].rob; mo.op = m[sel].op; mo.it = m[sel].it; mo.oth = m[sel].oth;
          mo.v1 = m[sel].v1; mo.v2 = m[sel].v2;
          m[sel].busy = 0;
        end
        for (int i = 0; i < N; i++) begin
          resolve(m[i].p1, m[i].t1, m[i].v1);
          resolve(m[i].p2, m[i].t2, m[i].v2);
        end
        if (disp_valid && fr >= 0) begin
          m[fr].busy = 1; m[fr].rob = disp_rob_id; m[fr].op = disp_op;
          m[fr].it = disp_instr_type; m[fr].oth = disp_op_other;
          m[fr].p1 = disp_q1_busy; m[fr].t1 = disp_q1; m[fr].v1 = disp_v1;
          m[fr].p2 = disp_q2_busy; m[fr].t2 = disp_q2; m[fr].v2 = disp_v2;
          resolve(m[fr].p1, m[fr].t1, m[fr].v1);
          resolve(m[fr].p2, m[fr].t2, m[fr].v2);
        end
      end
      cnt = 0;
      for (int i = 0; i < N; i++) if (m[i].busy) cnt++;
      mo.full = (cnt == N);
      q.push_back(mo);
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every predicted output set one step after its edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("issue_valid", 96'(issue_valid), 96'(e.valid));
        chk("full", 96'(full), 96'(e.full));
        chk("issue_fields",
            96'({issue_rob_id, issue_op, issue_instr_type, issue_op_other, issue_v1, issue_v2}),
            96'({e.rob, e.op, e.it, e.oth, e.v1, e.v2}));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    disp_valid = 0; cdb_alu_ready = 0; cdb_lsb_ready = 0; rob_clear = 0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic [2:0] op, input bit oth,
                      input logic [31:0] v1, input bit p1, input logic [3:0] t1,
                      input logic [31:0] v2, input bit p2, input logic [3:0] t2);
    disp_valid = 1; disp_rob_id = rob; disp_op = op; disp_instr_type = OP_REG;
    disp_op_other = oth; disp_v1 = v1; disp_q1_busy = p1; disp_q1 = t1;
    disp_v2 = v2; disp_q2_busy = p2; disp_q2 = t2;
  endtask

  task automatic bcast(input bit alu, input logic [3:0] tag, input logic [31:0] res);
    if (alu) begin cdb_alu_ready = 1; cdb_alu_rob_id = tag; cdb_alu_result = res; end
    else begin cdb_lsb_ready = 1; cdb_lsb_rob_id = tag; cdb_lsb_result = res; end
  endtask

  initial begin
    rst = 1; rdy = 1; rob_clear = 0; disp_valid = 0;
    disp_rob_id = 0; disp_op = 0; disp_instr_type = 0; disp_op_other = 0;
    disp_v1 = 0; disp_v2 = 0; disp_q1_busy = 0; disp_q2_busy = 0; disp_q1 = 0; disp_q2 = 0;
    cdb_alu_ready = 0; cdb_alu_rob_id = 0; cdb_alu_result = 0;
    cdb_lsb_ready = 0; cdb_lsb_rob_id = 0; cdb_lsb_result = 0;
    cyc(); cyc();
    rst = 0;

    // Ready add issues one cycle after dispatch.
    disp(3, 3'b000, 0, 5, 0, 0, 7, 0, 0); cyc();
    repeat (3) cyc();

    // LSB wakeup of operand 1.
    disp(2, 3'b100, 0, 0, 1, 9, 1, 0, 0); cyc();
    cyc();
    bcast(0, 9, 32'h10); cyc();
    repeat (3) cyc();

    // Dispatch bypass from the ALU bus on operand 2.
    disp(5, 3'b000, 1, 32'h22, 0, 0, 0, 1, 4);
    bcast(1, 4, 32'hFFFF_FFFF); cyc();
    repeat (3) cyc();

    // Fill every entry, attempt an overflow dispatch, then release all at once.
    for (int i = 0; i < N; i++) begin
      disp(4'(i + 8), 3'(i), 0, 32'(i), 1, 1, 32'(100 + i), 0, 0); cyc();
    end
    disp(15, 3'b111, 1, 1, 0, 0, 1, 0, 0); cyc();
    bcast(1, 1, 32'hABCD_0001); cyc();
    repeat (10) cyc();

    // Flush with three pending entries and a same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      disp(4'(i), 3'b001, 0, 0, 1, 6, 3, 0, 0); cyc();
    end
    disp(7, 3'b010, 0, 1, 0, 0, 2, 0, 0); rob_clear = 1; cyc();
    cyc();
    bcast(1, 6, 32'h55); cyc();
    repeat (3) cyc();

    // Ready entry held by rdy low for three cycles.
    disp(11, 3'b110, 0, 32'h77, 0, 0, 32'h88, 0, 0); cyc();
    rdy = 0; repeat (3) cyc();
    rdy = 1; repeat (3) cyc();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) rob_clear = 1;
      if ($urandom_range(0, 99) < 55)
        disp(4'($urandom_range(0, 15)), 3'($urandom), 1'($urandom), $urandom,
             1'($urandom), 4'($urandom_range(0, 7)), $urandom,
             1'($urandom), 4'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) < 30) bcast(1, 4'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 99) < 30) begin
        bcast(0, 4'($urandom_range(0, 7)), $urandom);
        if (cdb_alu_ready && cdb_lsb_rob_id == cdb_alu_rob_id) cdb_lsb_rob_id = cdb_alu_rob_id ^ 4'h1;
      end
      cyc();
    end
    rdy = 1;
    repeat (4) cyc();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
